button_conditioner: RTL and testbench

//   Converts raw, asynchronous, bouncing push-button inputs into clean, single-cycle

---
 rtl/button_conditioner.sv | 117 +++++++++++
 tb/tb_button_conditioner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: per-button 2-flop synchronizer, debounce filter,
// press/release edge detect and optional auto-repeat, all in one clock domain.
module button_conditioner #(
  parameter int                  NUM_BTNS        = 5,
  parameter int                  DEBOUNCE_CYCLES = 655,
  parameter int                  HOLD_CYCLES     = 16384,
  parameter int                  REPEAT_CYCLES   = 3277,
  parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = 5'b01100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_repeat,
  output logic [NUM_BTNS-1:0] btn_event
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX) + 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic          level_d;
    logic          prev_q;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        level_q <= 1'b0;
        prev_q  <= 1'b0;
        dcnt_q  <= '0;
      end else begin
        s1_q    <= btn_raw[i];
        s2_q    <= s1_q;
        level_q <= level_d;
        prev_q  <= level_q;
        dcnt_q  <= dcnt_d;
      end
    end

    // Any sample that agrees with the accepted level restarts the stability count,
    // so a glitch shorter than DEBOUNCE_CYCLES leaves no trace.
    always_comb begin
      level_d = level_q;
      dcnt_d  = '0;
      if (s2_q != level_q) begin
        if (dcnt_q == DB_LAST) begin
          level_d = s2_q;
        end else begin
          dcnt_d = dcnt_q + DB_ONE;
        end
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = level_q & ~prev_q;
    assign btn_release[i] = ~level_q & prev_q;

    if (REPEAT_MASK[i]) begin : g_rep
      localparam logic [HW-1:0] HOLD_T = HW'(HOLD_CYCLES);
      localparam logic [HW-1:0] REP_T  = HW'(REPEAT_CYCLES);
      localparam logic [HW-1:0] H_ONE  = HW'(1);

      logic [HW-1:0] hcnt_q;
      logic [HW-1:0] hcnt_d;
      logic          phase_q;
      logic          phase_d;
      logic          hit;

      // hcnt counts cycles since the press cycle (or since the last repeat);
      // phase selects the initial hold delay versus the shorter repeat interval.
      assign hit = level_q & (hcnt_q == (phase_q ? REP_T : HOLD_T));

      always_ff @(posedge clk) begin
        if (rst) begin
          hcnt_q  <= '0;
          phase_q <= 1'b0;
        end else begin
          hcnt_q  <= hcnt_d;
          phase_q <= phase_d;
        end
      end

      always_comb begin
        hcnt_d  = hcnt_q;
        phase_d = phase_q;
        if (!level_q) begin
          hcnt_d  = '0;
          phase_d = 1'b0;
        end else if (hit) begin
          hcnt_d  = H_ONE;
          phase_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + H_ONE;
        end
      end

      assign btn_repeat[i] = hit;
    end else begin : g_norep
      assign btn_repeat[i] = 1'b0;
    end
  end

  assign btn_event = btn_press | btn_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat periods
// so every corner (bounce, repeat cadence, reset during hold) fits in a few hundred cycles.
module tb_button_conditioner;

  localparam int N = 5;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;
  logic [N-1:0] btn_event;

  int checks;
  int failures;

  button_conditioner #(
    .NUM_BTNS        (N),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3),
    .REPEAT_MASK     (5'b01100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .btn_event   (btn_event)
  );

  // clock / reset block
  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    btn_raw = '0;
  end
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [N-1:0] raw, input logic [N-1:0] lvl,
                     input logic [N-1:0] prs, input logic [N-1:0] rel, input logic [N-1:0] rpt);
    vec_t v;
    v.rst = r;
    v.raw = raw;
    v.lvl = lvl;
    v.prs = prs;
    v.rel = rel;
    v.rpt = rpt;
    vecs.push_back(v);
  endtask

  // driver: apply inputs, clock once, sample 1 time unit after the edge
  task automatic step(input logic r, input logic [N-1:0] raw);
    rst     = r;
    btn_raw = raw;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [N-1:0] lvl, input logic [N-1:0] prs,
                         input logic [N-1:0] rel, input logic [N-1:0] rpt);
    chk({name, "_level"},   btn_level,   lvl);
    chk({name, "_press"},   btn_press,   prs);
    chk({name, "_release"}, btn_release, rel);
    chk({name, "_repeat"},  btn_repeat,  rpt);
    chk({name, "_event"},   btn_event,   prs | rpt);
  endtask

  // step until btn_press[bit] fires; returns the number of steps taken (0 if never)
  task automatic wait_press(input int bit_i, input logic [N-1:0] raw, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, raw);
      if (btn_press[bit_i]) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int           lat;
    int           ev_cnt;
    int           rpt_cnt;
    logic [N-1:0] e_lvl;
    logic [N-1:0] e_prs;
    logic [N-1:0] e_rel;
    logic [N-1:0] e_rpt;

    checks   = 0;
    failures = 0;

    // reset, clean step on bit0, bounce and short pulse on bit1
    add(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    for (int k = 0; k < 4; k++) add(0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00000);
    add(0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    for (int k = 0; k < 5; k++) add(0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000);
    add(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    for (int k = 0; k < 3; k++) add(0, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    for (int k = 0; k < 6; k++) add(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    for (int k = 0; k < 4; k++) add(0, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b00000, 5'b00010, 5'b00010, 5'b00000, 5'b00000);
    for (int k = 0; k < 3; k++) add(0, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000);
    for (int k = 0; k < 3; k++) add(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].raw);
      chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].rpt);
    end

    // idle with raw low: nothing may move
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 5'b00000);
      chk($sformatf("idle%0d", k), {btn_level, btn_press, btn_release, btn_event}, 32'd0);
    end

    // repeat cadence on bit2, with release landing just after a repeat
    wait_press(2, 5'b00100, lat);
    chk("t4_press_latency", lat, 6);
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, (k < 17) ? 5'b00100 : 5'b00000);
      e_lvl = (k <= 21) ? 5'b00100 : 5'b00000;
      e_rel = (k == 22) ? 5'b00100 : 5'b00000;
      e_rpt = (k == 10 || k == 13 || k == 16 || k == 19) ? 5'b00100 : 5'b00000;
      chk_all($sformatf("t4_hold%0d", k), e_lvl, 5'b00000, e_rel, e_rpt);
    end
    wait_press(2, 5'b00100, lat);
    chk("t4_repress_latency", lat, 6);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 5'b00100);
      e_rpt = (k == 10) ? 5'b00100 : 5'b00000;
      chk_all($sformatf("t4_rehold%0d", k), 5'b00100, 5'b00000, 5'b00000, e_rpt);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 5'b00000);
    chk("t4_settled_level", btn_level, 5'b00000);

    // bit0 has no auto-repeat: one event for a long hold
    ev_cnt  = 0;
    rpt_cnt = 0;
    for (int k = 0; k < 46; k++) begin
      step(1'b0, 5'b00001);
      if (btn_event[0]) ev_cnt++;
      if (btn_repeat[0]) rpt_cnt++;
    end
    chk("t5_level_held", btn_level, 5'b00001);
    chk("t5_event_count", ev_cnt, 1);
    chk("t5_repeat_count", rpt_cnt, 0);
    for (int k = 0; k < 10; k++) step(1'b0, 5'b00000);
    chk("t5_settled_level", btn_level, 5'b00000);

    // bits 2 and 3 together, reset pulsed mid-hold, held through reset
    wait_press(2, 5'b01100, lat);
    chk("t6_press_latency", lat, 6);
    chk("t6_press_both", btn_press, 5'b01100);
    for (int k = 0; k < 5; k++) step(1'b0, 5'b01100);
    step(1'b1, 5'b01100);
    chk_all("t6_in_reset", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    for (int n = 1; n <= 17; n++) begin
      step(1'b0, 5'b01100);
      e_lvl = (n >= 6)  ? 5'b01100 : 5'b00000;
      e_prs = (n == 6)  ? 5'b01100 : 5'b00000;
      e_rpt = (n == 16) ? 5'b01100 : 5'b00000;
      chk_all($sformatf("t6_post%0d", n), e_lvl, e_prs, 5'b00000, e_rpt);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 5'b00000);
    chk("t6_settled_level", btn_level, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
